// File: rtl/vga_timing_ctrl_if.sv
// Signal bundle between vga_timing_ctrl, its renderer and the VGA connector pins.
interface vga_timing_ctrl_if;
   logic [9:0]  col;
   logic [9:0]  row;
   logic        pix_tick;
   logic        frame_start;
   logic        hs;
   logic        vs;
   logic [3:0]  r;
   logic [3:0]  g;
   logic [3:0]  b;
   logic [11:0] rgb_in;
   logic        test_mode;

   modport master (
      output col, row, pix_tick, frame_start, hs, vs, r, g, b,
      input  rgb_in, test_mode
   );

   modport slave (
      input  col, row, pix_tick, frame_start, hs, vs, r, g, b,
      output rgb_in, test_mode
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster generator: presents col/row, samples rgb_in one pixel later and drives hs/vs/rgb pins.
// Optional colour-bar generator is compiled in when VGA_TEST_PATTERN_EN is defined.
module vga_timing_ctrl #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned CLK_DIV   = 4,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0
) (
   input logic               clk,
   input logic               rst,
   vga_timing_ctrl_if.master bus
);
   localparam int unsigned CNT_W    = 10;
   localparam int unsigned RGB_W    = 12;
   localparam int unsigned DIV_W    = $clog2(CLK_DIV);
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_tick_q, pix_tick_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic             frame_start_q, frame_start_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;

   logic             vis_c;
   logic             hs_act_c;
   logic             vs_act_c;
   logic             h_last_c;
   logic             v_last_c;
   logic [RGB_W-1:0] pix_c;

   // Decode of the coordinate currently presented to the renderer.
   assign vis_c    = (h_q < CNT_W'(H_VISIBLE)) && (v_q < CNT_W'(V_VISIBLE));
   assign hs_act_c = (h_q >= CNT_W'(HS_START)) && (h_q < CNT_W'(HS_END));
   assign vs_act_c = (v_q >= CNT_W'(VS_START)) && (v_q < CNT_W'(VS_END));
   assign h_last_c = (h_q == CNT_W'(H_TOTAL - 1));
   assign v_last_c = (v_q == CNT_W'(V_TOTAL - 1));

`ifdef VGA_TEST_PATTERN_EN
   // Bar index is col/64; columns 512..639 fold back onto bars 0..1.
   logic [2:0] bar_c;
   assign bar_c = h_q[8:6];
   assign pix_c = bus.test_mode ? {{4{bar_c[0]}}, {4{bar_c[1]}}, {4{bar_c[2]}}} : bus.rgb_in;
`else
   logic unused_test_mode_c;
   assign unused_test_mode_c = bus.test_mode;
   assign pix_c              = bus.rgb_in;
`endif

   // Divider, raster counters and the pixel-delayed pin stage.
   always_comb begin
      div_d         = div_q;
      pix_tick_d    = 1'b0;
      h_d           = h_q;
      v_d           = v_q;
      frame_start_d = 1'b0;
      hs_d          = hs_q;
      vs_d          = vs_q;
      rgb_d         = rgb_q;

      div_d      = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
      pix_tick_d = (div_d == DIV_W'(CLK_DIV - 1));

      if (pix_tick_q) begin
         if (h_last_c) begin
            h_d           = '0;
            v_d           = v_last_c ? '0 : v_q + CNT_W'(1);
            frame_start_d = v_last_c;
         end else begin
            h_d = h_q + CNT_W'(1);
         end
         // Pins take the pre-advance coordinate so they line up with the sampled colour.
         hs_d  = hs_act_c ? HS_POL : ~HS_POL;
         vs_d  = vs_act_c ? VS_POL : ~VS_POL;
         rgb_d = vis_c ? pix_c : '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q         <= '0;
         pix_tick_q    <= 1'b0;
         h_q           <= '0;
         v_q           <= '0;
         frame_start_q <= 1'b0;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         rgb_q         <= '0;
      end else begin
         div_q         <= div_d;
         pix_tick_q    <= pix_tick_d;
         h_q           <= h_d;
         v_q           <= v_d;
         frame_start_q <= frame_start_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         rgb_q         <= rgb_d;
      end
   end

   assign bus.col         = h_q;
   assign bus.row         = v_q;
   assign bus.pix_tick    = pix_tick_q;
   assign bus.frame_start = frame_start_q;
   assign bus.hs          = hs_q;
   assign bus.vs          = vs_q;
   assign bus.r           = rgb_q[11:8];
   assign bus.g           = rgb_q[7:4];
   assign bus.b           = rgb_q[3:0];
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunken raster: per-clock raster model, pin scoreboard,
// vector table for colour/blanking/pattern, and hand sequences for reset and frame timing.
module tb_vga_timing_ctrl;
   localparam int unsigned HV = 464, HF = 8, HSW = 16, HB = 8;
   localparam int unsigned VV = 3, VF = 1, VSW = 2, VB = 1;
   localparam int unsigned CD = 4;
   localparam bit HP = 1'b0, VP = 1'b0;
   localparam int unsigned HT = HV + HF + HSW + HB;
   localparam int unsigned VT = VV + VF + VSW + VB;
   localparam int unsigned HS0 = HV + HF, HS1 = HS0 + HSW;
   localparam int unsigned VS0 = VV + VF, VS1 = VS0 + VSW;
   localparam int unsigned FRAME_CLK = HT * VT * CD;
`ifdef VGA_TEST_PATTERN_EN
   localparam bit PAT = 1'b1;
`else
   localparam bit PAT = 1'b0;
`endif

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } pins_t;

   typedef struct {
      int unsigned h;
      int unsigned v;
      logic [11:0] rgb;
      logic        tm;
      logic [11:0] exp_rgb;
   } vec_t;

   localparam pins_t PINS_RST = {~HP, ~VP, 12'h000};
   localparam int NV = 11;

   logic clk;
   logic rst;
   vga_timing_ctrl_if bus ();

   vga_timing_ctrl #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
      .CLK_DIV(CD), .HS_POL(HP), .VS_POL(VP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned n_edges  = 0;
   int unsigned clk_count = 0;
   int unsigned m_h = 0, m_v = 0, m_ph = 0;
   pins_t       exp_q[$];
   pins_t       cur;
   bit          ovr_valid = 1'b0, ovr_used = 1'b0;
   int unsigned ovr_h, ovr_v;
   logic [11:0] ovr_rgb;
   logic        ovr_tm;
   int unsigned hs_run, vs_run, fs_seen = 0;
   int unsigned last_fs, last_hfall;
   bit          prev_hs, prev_vs;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic pins_t model_pins(input int unsigned h, input int unsigned v,
                                        input logic [11:0] rgb, input logic tm);
      pins_t p;
      int unsigned k;
      k     = (h / 64) % 8;
      p.hs  = (h >= HS0 && h < HS1) ? HP : ~HP;
      p.vs  = (v >= VS0 && v < VS1) ? VP : ~VP;
      p.rgb = 12'h000;
      if (h < HV && v < VV) begin
         if (PAT && tm)
            p.rgb = {(k % 2 == 1) ? 4'hF : 4'h0, ((k / 2) % 2 == 1) ? 4'hF : 4'h0,
                     ((k / 4) % 2 == 1) ? 4'hF : 4'h0};
         else
            p.rgb = rgb;
      end
      return p;
   endfunction

   // Drive the colour for the coordinate just presented and queue the pins it must produce.
   task automatic present(input int unsigned h, input int unsigned v);
      logic [11:0] rgb;
      logic        tm;
      if (ovr_valid && ovr_h == h && ovr_v == v) begin
         rgb       = ovr_rgb;
         tm        = ovr_tm;
         ovr_valid = 1'b0;
         ovr_used  = 1'b1;
      end else begin
         rgb = 12'($urandom);
         tm  = 1'($urandom_range(0, 1));
      end
      bus.rgb_in    = rgb;
      bus.test_mode = tm;
      exp_q.push_back(model_pins(h, v, rgb, tm));
   endtask

   task automatic chk_rst();
      check("rst_col", 32'(bus.col), 0);
      check("rst_row", 32'(bus.row), 0);
      check("rst_pix_tick", 32'(bus.pix_tick), 0);
      check("rst_frame_start", 32'(bus.frame_start), 0);
      check("rst_pins", 32'({bus.hs, bus.vs, bus.r, bus.g, bus.b}), 32'(PINS_RST));
   endtask

   task automatic release_reset();
      rst        = 1'b1;
      n_edges    = 0;
      exp_q.delete();
      cur        = PINS_RST;
      hs_run     = 0;
      vs_run     = 0;
      prev_hs    = 1'b0;
      prev_vs    = 1'b0;
      last_hfall = 0;
      last_fs    = 0;
      present(0, 0);
   endtask

   // One clock: compare raster outputs against the edge count since reset release.
   task automatic cycle();
      int unsigned t, pt, ph_c, pv_c;
      @(negedge clk);
      n_edges++;
      clk_count++;
      m_ph = n_edges % CD;
      t    = n_edges / CD;
      m_h  = t % HT;
      m_v  = (t / HT) % VT;
      check("col", 32'(bus.col), m_h);
      check("row", 32'(bus.row), m_v);
      check("pix_tick", 32'(bus.pix_tick), (m_ph == CD - 1) ? 1 : 0);
      check("frame_start", 32'(bus.frame_start), (m_ph == 0 && m_h == 0 && m_v == 0) ? 1 : 0);
      if (m_ph == 0) begin
         if (exp_q.size() == 0) check("scoreboard_underflow", 0, 1);
         else cur = exp_q.pop_front();
         pt   = t - 1;
         ph_c = pt % HT;
         pv_c = (pt / HT) % VT;
         if (bus.hs == HP && !prev_hs) begin
            check("hs_first_col", ph_c, HS0);
            if (last_hfall != 0) check("hs_period_clk", clk_count - last_hfall, HT * CD);
            last_hfall = clk_count;
         end
         if (bus.hs != HP && prev_hs) begin
            check("hs_width_ticks", hs_run, HSW);
            hs_run = 0;
         end
         if (bus.hs == HP) hs_run++;
         prev_hs = (bus.hs == HP);
         if (bus.vs == VP && !prev_vs) check("vs_first_row", pv_c, VS0);
         if (bus.vs != VP && prev_vs) begin
            check("vs_width_ticks", vs_run, VSW * HT);
            vs_run = 0;
         end
         if (bus.vs == VP) vs_run++;
         prev_vs = (bus.vs == VP);
         present(m_h, m_v);
      end
      check("pins", 32'({bus.hs, bus.vs, bus.r, bus.g, bus.b}), 32'(cur));
      if (bus.frame_start) begin
         fs_seen++;
         if (last_fs != 0) check("frame_period_clk", clk_count - last_fs, FRAME_CLK);
         last_fs = clk_count;
      end
   endtask

   initial begin
      vec_t        vecs[NV];
      int unsigned budget;

      vecs[0]  = '{100, 0, 12'hABC, 1'b0, 12'hABC};
      vecs[1]  = '{200, 0, 12'hABC, 1'b1, PAT ? 12'hFF0 : 12'hABC};
      vecs[2]  = '{HV, 0, 12'hFFF, 1'b0, 12'h000};
      vecs[3]  = '{0, 1, 12'h000, 1'b1, 12'h000};
      vecs[4]  = '{64, 1, 12'h000, 1'b1, PAT ? 12'hF00 : 12'h000};
      vecs[5]  = '{130, 1, 12'h000, 1'b1, PAT ? 12'h0F0 : 12'h000};
      vecs[6]  = '{448, 1, 12'h000, 1'b1, PAT ? 12'hFFF : 12'h000};
      vecs[7]  = '{450, 1, 12'h5A5, 1'b0, 12'h5A5};
      vecs[8]  = '{HV - 1, 2, 12'h5A5, 1'b0, 12'h5A5};
      vecs[9]  = '{5, VV, 12'hFFF, 1'b0, 12'h000};
      vecs[10] = '{HT - 1, VT - 1, 12'hFFF, 1'b1, 12'h000};

      // Power-on reset with the clock running and inputs toggling.
      rst           = 1'b0;
      bus.rgb_in    = 12'hFFF;
      bus.test_mode = 1'b1;
      repeat (3) begin
         @(negedge clk);
         clk_count++;
         bus.rgb_in = ~bus.rgb_in;
      end
      chk_rst();
      release_reset();

      // Colour passthrough, blanking and bar pattern at chosen coordinates.
      for (int i = 0; i < NV; i++) begin
         ovr_h     = vecs[i].h;
         ovr_v     = vecs[i].v;
         ovr_rgb   = vecs[i].rgb;
         ovr_tm    = vecs[i].tm;
         ovr_used  = 1'b0;
         ovr_valid = 1'b1;
         budget    = 0;
         while (!ovr_used && budget < 2 * FRAME_CLK) begin
            cycle();
            budget++;
         end
         if (!ovr_used) begin
            check($sformatf("vec%0d_reached", i), 0, 1);
            ovr_valid = 1'b0;
         end else begin
            repeat (CD) cycle();
            check($sformatf("vec%0d_rgb", i), 32'({bus.r, bus.g, bus.b}), 32'(vecs[i].exp_rgb));
         end
      end

      // Run on to the second frame boundary for line/frame/sync timing.
      budget = 0;
      while (fs_seen < 2 && budget < 3 * FRAME_CLK) begin
         cycle();
         budget++;
      end
      check("frames_seen", fs_seen, 2);

      // Asynchronous reset in the middle of a pixel, mid-frame.
      budget = 0;
      while (!(m_h == 400 && m_v == 2 && m_ph == 2) && budget < 2 * FRAME_CLK) begin
         cycle();
         budget++;
      end
      check("midreset_reached", (m_h == 400 && m_v == 2) ? 1 : 0, 1);
      rst = 1'b0;
      #1;
      chk_rst();
      repeat (3) begin
         @(negedge clk);
         clk_count++;
         chk_rst();
      end
      release_reset();
      repeat ((HS1 + 4) * CD) cycle();
      check("hs_after_restart", (last_hfall != 0) ? 1 : 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end
endmodule
